// File: rtl/seq_stream_ctrl_if.sv
// Word-wide valid/ready input channel feeding seq_stream_ctrl.
// The producer side uses master, the controller uses slave.
interface seq_stream_ctrl_if #(
    parameter int unsigned WORD_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_stream_ctrl.sv
// Serialises accepted words MSB first into a programmable pattern matcher
// whose bit history runs continuously across words; counts hits with saturation.
module seq_stream_ctrl #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned LEN_W  = $clog2(PAT_MAX) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    seq_stream_ctrl_if.slave   in_bus,
    output logic               ser_valid,
    output logic               ser_bit,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done,
    output logic               busy
);
    localparam int unsigned IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [WORD_W-1:0]  sreg;
    logic [IDX_W-1:0]   idx;
    logic [PAT_MAX-1:0] hist;
    logic [LEN_W-1:0]   hist_cnt;
    logic [PAT_MAX-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;

    logic [PAT_MAX-1:0] nxt_hist;
    logic [LEN_W-1:0]   nxt_cnt;
    logic [PAT_MAX-1:0] mask;
    logic               hit;
    logic               cfg_ok;
    logic               accept;

    always_comb begin
        nxt_hist = {hist[PAT_MAX-2:0], ser_bit};
        nxt_cnt  = (hist_cnt >= LEN_W'(PAT_MAX)) ? hist_cnt : hist_cnt + LEN_W'(1);
        mask     = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < 32'(len));
        end
        // a clr in the same cycle discards the bit, so no hit may be reported
        hit    = (state == SHIFT) && !clr && (nxt_cnt >= len) &&
                 (((nxt_hist ^ pattern) & mask) == '0);
        cfg_ok = cfg_we && (state == IDLE) &&
                 (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
        accept = (state == IDLE) && in_bus.in_valid && in_bus.in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            sreg            <= '0;
            idx             <= '0;
            in_bus.in_ready <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            match           <= 1'b0;
            cfg_err         <= 1'b0;
            ser_valid       <= 1'b0;
            ser_bit         <= 1'b0;
            match_cnt       <= '0;
            hist            <= '0;
            hist_cnt        <= '0;
            pattern         <= PAT_MAX'(4'b1010);
            len             <= LEN_W'(4);
            overlap         <= 1'b1;
        end else begin
            done    <= 1'b0;
            match   <= hit;
            cfg_err <= cfg_we && !cfg_ok;

            if (cfg_ok) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg            <= {in_bus.in_data[WORD_W-2:0], 1'b0};
                        ser_bit         <= in_bus.in_data[WORD_W-1];
                        ser_valid       <= 1'b1;
                        idx             <= '0;
                        in_bus.in_ready <= 1'b0;
                        busy            <= 1'b1;
                        state           <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx == IDX_W'(WORD_W - 1)) begin
                        ser_valid <= 1'b0;
                        ser_bit   <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ser_bit <= sreg[WORD_W-1];
                        sreg    <= sreg << 1;
                        idx     <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    busy            <= 1'b0;
                    in_bus.in_ready <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (clr || cfg_ok) begin
                hist      <= '0;
                hist_cnt  <= '0;
                match_cnt <= '0;
            end else if (state == SHIFT) begin
                hist     <= nxt_hist;
                hist_cnt <= (hit && !overlap) ? '0 : nxt_cnt;
                if (hit && (match_cnt != '1)) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboard bench for seq_stream_ctrl: stimulus pushes expected bits, hit counts
// and done events; a negedge monitor pops and compares whenever the DUT presents them.
module tb_seq_stream_ctrl;
    localparam int unsigned W  = 16;
    localparam int unsigned PM = 8;
    localparam int unsigned CW = 3;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          cfg_we = 1'b0;
    logic [PM-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          cfg_err;
    logic          ser_valid;
    logic          ser_bit;
    logic          match;
    logic [CW-1:0] match_cnt;
    logic          done;
    logic          busy;

    seq_stream_ctrl_if #(.WORD_W(W)) bus ();

    seq_stream_ctrl #(.WORD_W(W), .PAT_MAX(PM), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_err     (cfg_err),
        .in_bus      (bus.slave),
        .ser_valid   (ser_valid),
        .ser_bit     (ser_bit),
        .match       (match),
        .match_cnt   (match_cnt),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } done_t;

    logic  exp_bits[$];
    int    exp_mcnt[$];
    done_t exp_done[$];
    done_t d;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (ser_valid) begin
                check("in_ready_in_shift", bus.in_ready, 0);
                if (exp_bits.size() == 0) fail_now("ser_bit_extra");
                else check("ser_bit", ser_bit, exp_bits.pop_front());
            end
            if (match) begin
                if (exp_mcnt.size() == 0) fail_now("match_extra");
                else check("match_cnt_at_hit", match_cnt, exp_mcnt.pop_front());
            end
            if (done) begin
                check("in_ready_in_done", bus.in_ready, 0);
                if (exp_done.size() == 0) fail_now("done_extra");
                else begin
                    d = exp_done.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_match_cnt", match_cnt, d.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mcnt(input int first, input int last);
        for (int v = first; v <= last; v++) exp_mcnt.push_back(v);
    endtask

    task automatic push_bits(input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) exp_bits.push_back(w[W-1-i]);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) fail_now(name);
    endtask

    // returns in cycle T+1, where T is the accept cycle
    task automatic send_word(input logic [W-1:0] w, input int nbits,
                             input bit has_done, input int cnt);
        done_t e;
        wait_ready("send_timeout");
        push_bits(w, nbits);
        if (has_done) begin
            e.cyc = cyc + W + 1;
            e.cnt = cnt;
            exp_done.push_back(e);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [PM-1:0] p, input logic [LW-1:0] l,
                             input logic ov, input logic exp_err);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        tick();
        cfg_we = 1'b0;
        check("cfg_err", cfg_err, exp_err);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        done_t e;
        int    t0;
        int    n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_match", match, 0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        tick();

        // default 1010 overlap: 7 hits
        push_mcnt(1, 7);
        send_word(16'hAAAA, W, 1, 7);
        wait_ready("idle_t1");

        // non-overlap: 4 hits
        cfg_write(8'b1010, 4'd4, 1'b0, 1'b0);
        check("cfg_clears_cnt", match_cnt, 0);
        push_mcnt(1, 4);
        send_word(16'hAAAA, W, 1, 4);
        wait_ready("idle_t2");

        // history across words
        cfg_write(8'b1010, 4'd4, 1'b1, 1'b0);
        send_word(16'h0005, W, 1, 0);
        wait_ready("idle_t3a");
        push_mcnt(1, 1);
        send_word(16'h0000, W, 1, 1);
        wait_ready("idle_t3b");

        // rejected writes: len 0 in IDLE, any write while shifting
        cfg_write(8'h01, 4'd0, 1'b0, 1'b1);
        push_mcnt(2, 7);
        push_mcnt(7, 7);
        send_word(16'hAAAA, W, 1, 7);
        cfg_write(8'h01, 4'd1, 1'b0, 1'b1);
        wait_ready("idle_t4");

        // saturation with single-bit pattern
        cfg_write(8'h01, 4'd1, 1'b1, 1'b0);
        push_mcnt(1, 7);
        for (int i = 0; i < 9; i++) exp_mcnt.push_back(7);
        send_word(16'hFFFF, W, 1, 7);
        wait_ready("idle_t5a");
        pulse_clr();
        check("clr_idle_cnt", match_cnt, 0);

        // clr on bit 10 discards that bit, suppresses its hit, word keeps going
        push_mcnt(1, 7);
        push_mcnt(7, 7);
        push_mcnt(7, 7);
        push_mcnt(1, 6);
        send_word(16'hFFFF, W, 1, 6);
        repeat (9) tick();
        pulse_clr();
        wait_ready("idle_t5b");

        // back-to-back with in_valid held
        pulse_clr();
        push_mcnt(1, 6);
        t0 = cyc;
        push_bits(16'h00F0, W);
        push_bits(16'h8001, W);
        e.cyc = t0 + W + 1;
        e.cnt = 4;
        exp_done.push_back(e);
        e.cyc = t0 + 2 * W + 3;
        e.cnt = 6;
        exp_done.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00F0;
        tick();
        bus.in_data = 16'h8001;
        repeat (W + 1) tick();
        check("b2b_ready_at_T+W+2", bus.in_ready, 1);
        check("b2b_busy_before_second", busy, 0);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_second_accepted", busy, 1);
        wait_ready("idle_t6");

        // async reset at shift cycle 5
        pulse_clr();
        push_mcnt(1, 3);
        send_word(16'hFFFF, 4, 0, 0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("arst_ser_valid", ser_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_match", match, 0);
        check("arst_match_cnt", match_cnt, 0);
        check("arst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();

        // config must be back to 1010/4/overlap
        push_mcnt(1, 7);
        send_word(16'hAAAA, W, 1, 7);
        wait_ready("idle_t7");

        n = 0;
        while ((exp_bits.size() + exp_mcnt.size() + exp_done.size()) != 0 && n < 40) begin
            tick();
            n++;
        end
        check("left_bits", exp_bits.size(), 0);
        check("left_matches", exp_mcnt.size(), 0);
        check("left_done", exp_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
